// File: rtl/mac_accum_pkg.sv
// Shared DSP constants and helpers for the multiply-accumulate datapath.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mac_accum_pkg;

    localparam int DSP_A_WIDTH   = 18;
    localparam int DSP_B_WIDTH   = 18;
    localparam int DSP_ACC_WIDTH = 40;
    localparam int DSP_CNT_WIDTH = 8;

    // Two's-complement add overflow from the sign bits of both addends and the sum.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/mac_accum_smul_pipe.sv
// Registered signed multiplier carrying beat valid and frame-last alongside the product.
// Latency: 1 cycle from an enabled input to p/p_valid/p_last.
// Backpressure: all registers hold while en is low.
module smul_pipe
    import mac_accum_pkg::*;
#(
    parameter int A_WIDTH = DSP_A_WIDTH,
    parameter int B_WIDTH = DSP_B_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic                              in_valid,
    input  logic                              in_last,
    input  logic signed [A_WIDTH-1:0]         a,
    input  logic signed [B_WIDTH-1:0]         b,
    output logic                              p_valid,
    output logic                              p_last,
    output logic signed [A_WIDTH+B_WIDTH-1:0] p
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            p       <= '0;
        end else if (en) begin
            p_valid <= in_valid;
            p_last  <= in_last;
            p       <= P_WIDTH'(a) * P_WIDTH'(b);
        end
    end

endmodule

// File: rtl/mac_accum.sv
// Frame-based signed multiply-accumulate with wrap-around overflow flag and beat count.
// Latency: last beat accepted in cycle n -> out_valid in cycle n+2 (no stall).
// Backpressure: in_ready = !out_valid || out_ready; a held result freezes the whole pipe.
module mac_accum
    import mac_accum_pkg::*;
#(
    parameter int A_WIDTH   = DSP_A_WIDTH,
    parameter int B_WIDTH   = DSP_B_WIDTH,
    parameter int ACC_WIDTH = DSP_ACC_WIDTH,
    parameter int CNT_WIDTH = DSP_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic signed [A_WIDTH-1:0] a,
    input  logic signed [B_WIDTH-1:0] b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_WIDTH-1:0]      dout,
    output logic [CNT_WIDTH-1:0]      out_len,
    output logic                      out_ovf
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    if (ACC_WIDTH < P_WIDTH) begin : g_width_check
        $error("mac_accum: ACC_WIDTH must be at least A_WIDTH+B_WIDTH");
    end

    logic                        advance;
    logic                        accepted;
    logic                        p_valid;
    logic                        p_last;
    logic signed [P_WIDTH-1:0]   p;
    logic signed [ACC_WIDTH-1:0] p_ext;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [CNT_WIDTH-1:0]        cnt;
    logic [CNT_WIDTH-1:0]        cnt_inc;
    logic                        sticky;
    logic                        ovf;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accepted = in_valid && advance;

    smul_pipe #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH)
    ) u_smul (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (advance),
        .in_valid (accepted),
        .in_last  (in_last),
        .a        (a),
        .b        (b),
        .p_valid  (p_valid),
        .p_last   (p_last),
        .p        (p)
    );

    // Sum wraps modulo 2^ACC_WIDTH; the flag tells the downstream saturate stage it happened.
    assign p_ext   = ACC_WIDTH'(p);
    assign sum     = acc + p_ext;
    assign ovf     = add_ovf(acc[ACC_WIDTH-1], p_ext[ACC_WIDTH-1], sum[ACC_WIDTH-1]);
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
            out_len   <= '0;
            out_ovf   <= 1'b0;
        end else if (advance) begin
            out_valid <= p_valid && p_last;
            if (p_valid) begin
                if (p_last) begin
                    dout    <= sum;
                    out_len <= cnt_inc;
                    out_ovf <= sticky || ovf;
                    acc     <= '0;
                    cnt     <= '0;
                    sticky  <= 1'b0;
                end else begin
                    acc     <= sum;
                    cnt     <= cnt_inc;
                    sticky  <= sticky || ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: a 40-bit and a 36-bit accumulator share one stimulus stream
// and are both scored against a plain-arithmetic frame model.
module tb_mac_accum;
    import mac_accum_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic               out_ready = 1'b1;
    logic signed [17:0] a_in = '0;
    logic signed [17:0] b_in = '0;

    logic        ir40, ov40, of40, ir36, ov36, of36;
    logic [39:0] d40;
    logic [35:0] d36;
    logic [7:0]  len40, len36;

    always #5 clk = ~clk;

    mac_accum u_dut40 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir40), .in_last(in_last),
        .a(a_in), .b(b_in), .out_valid(ov40), .out_ready(out_ready), .dout(d40),
        .out_len(len40), .out_ovf(of40)
    );

    mac_accum #(.ACC_WIDTH(36)) u_dut36 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir36), .in_last(in_last),
        .a(a_in), .b(b_in), .out_valid(ov36), .out_ready(out_ready), .dout(d36),
        .out_len(len36), .out_ovf(of36)
    );

    typedef struct {
        longint d40;
        longint d36;
        int     len;
        bit     o40;
        bit     o36;
    } exp_t;

    exp_t   expq[$];
    longint m_acc40 = 0, m_acc36 = 0;
    int     m_cnt = 0;
    bit     m_o40 = 0, m_o36 = 0;
    int     errors = 0, checks = 0;
    bit     rnd_ready = 0;

    localparam int AMIN = -131072;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Value of v reduced into an n-bit two's-complement range.
    function automatic longint wrapn(input longint v, input int n);
        longint m, r;
        m = longint'(1) <<< n;
        r = v & (m - 1);
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    function automatic bit out_of_range(input longint v, input int n);
        longint half;
        half = longint'(1) <<< (n - 1);
        return (v >= half) || (v < -half);
    endfunction

    // Scoreboard and frame model; everything sampled on the falling edge.
    always @(negedge clk) begin : compare
        longint prod, t40, t36;
        exp_t   e;
        if (!rst_n) begin
            check("rst_in_ready40", ir40, 1);
            check("rst_in_ready36", ir36, 1);
            check("rst_out_valid40", ov40, 0);
            check("rst_dout40", longint'(d40), 0);
            check("rst_len40", longint'(len40), 0);
            check("rst_ovf36", of36, 0);
            expq.delete();
            m_acc40 = 0; m_acc36 = 0; m_cnt = 0; m_o40 = 0; m_o36 = 0;
        end else begin
            check("in_ready40", ir40, !ov40 || out_ready);
            check("in_ready36", ir36, !ov36 || out_ready);
            if (expq.size() == 0) begin
                check("idle_valid40", ov40, 0);
                check("idle_valid36", ov36, 0);
            end else begin
                if (ov40) begin
                    check("dout40", longint'($signed(d40)), expq[0].d40);
                    check("len40", longint'(len40), expq[0].len);
                    check("ovf40", of40, expq[0].o40);
                end
                if (ov36) begin
                    check("dout36", longint'($signed(d36)), expq[0].d36);
                    check("len36", longint'(len36), expq[0].len);
                    check("ovf36", of36, expq[0].o36);
                end
                if (ov40 && out_ready) void'(expq.pop_front());
            end
            if (in_valid && ir40) begin
                prod = longint'(a_in) * longint'(b_in);
                t40 = m_acc40 + prod;
                t36 = m_acc36 + prod;
                m_o40 |= out_of_range(t40, 40);
                m_o36 |= out_of_range(t36, 36);
                m_acc40 = wrapn(t40, 40);
                m_acc36 = wrapn(t36, 36);
                m_cnt++;
                if (in_last) begin
                    e.d40 = m_acc40; e.d36 = m_acc36;
                    e.len = (m_cnt > 255) ? 255 : m_cnt;
                    e.o40 = m_o40; e.o36 = m_o36;
                    expq.push_back(e);
                    m_acc40 = 0; m_acc36 = 0; m_cnt = 0; m_o40 = 0; m_o36 = 0;
                end
            end
        end
    end

    // One clock: returns whether the current beat is taken on the coming edge.
    task automatic step(output bit took);
        @(negedge clk);
        took = in_valid && ir40 && rst_n;
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        bit took;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) step(took);
    endtask

    task automatic send(input int a, input int b, input bit last);
        bit took;
        int n;
        in_valid = 1'b1;
        a_in     = 18'(a);
        b_in     = 18'(b);
        in_last  = last;
        n = 0;
        do begin
            step(took);
            n++;
        end while (!took && n < 200);
        check("send_accepted", took, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input string name, input longint e40, input longint e36,
                               input int len, input bit o40, input bit o36);
        bit hit;
        hit = 0;
        in_valid = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (ov40 && out_ready) begin
                hit = 1;
                check({name, "_dout40"}, longint'($signed(d40)), e40);
                check({name, "_dout36"}, longint'($signed(d36)), e36);
                check({name, "_len"}, longint'(len40), len);
                check({name, "_ovf40"}, of40, o40);
                check({name, "_ovf36"}, of36, o36);
            end
            @(posedge clk);
            #1;
        end
        check({name, "_seen"}, hit, 1);
    endtask

    initial begin : stim
        bit took;
        int n, len, a, b;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("in_ready_after_reset", ir40, 1);

        // Four beats of 3*4; result appears exactly two cycles after the last beat.
        for (int i = 0; i < 3; i++) send(3, 4, 0);
        send(3, 4, 1);
        @(negedge clk);
        check("lat_cycle1_valid", ov40, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_cycle2_valid", ov40, 1);
        check("lat_dout", longint'($signed(d40)), 48);
        check("lat_len", longint'(len40), 4);
        check("lat_ovf", of40, 0);
        @(posedge clk);
        #1;

        send(AMIN, AMIN, 1);
        wait_result("single", 64'sd17179869184, 64'sd17179869184, 1, 0, 0);

        // Three max-positive products wrap a 36-bit accumulator but not a 40-bit one.
        send(AMIN, AMIN, 0);
        send(AMIN, AMIN, 0);
        send(AMIN, AMIN, 1);
        wait_result("wrap", 64'sd51539607552, -64'sd17179869184, 3, 0, 1);
        send(1, 1, 1);
        wait_result("post_wrap", 1, 1, 1, 0, 0);

        // Held result with a beat offered downstream of it.
        out_ready = 1'b0;
        send(5, 6, 0);
        send(5, 6, 1);
        idle(1);
        in_valid = 1'b1; a_in = 18'sd7; b_in = 18'sd8; in_last = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", ir40, 0);
            check("stall_valid", ov40, 1);
            check("stall_dout", longint'($signed(d40)), 60);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(7, 8, 0);
        send(1, 2, 1);
        wait_result("after_stall", 58, 58, 2, 0, 0);

        // Reset in the middle of a frame discards it.
        for (int i = 0; i < 3; i++) send(9, 9, 0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        check("in_ready_after_midreset", ir40, 1);
        send(1, 1, 0);
        send(2, 2, 1);
        wait_result("after_reset", 5, 5, 2, 0, 0);

        for (int i = 0; i < 299; i++) send(3, 4, 0);
        send(3, 4, 1);
        wait_result("long", 3600, 3600, 255, 0, 0);

        // Random frames, gaps and downstream stalls, scored by the model.
        rnd_ready = 1;
        for (int f = 0; f < 60; f++) begin
            len = (f % 20 == 5) ? int'($urandom_range(250, 270)) : int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
                if ($urandom_range(0, 3) == 0) begin
                    a = AMIN;
                    b = AMIN;
                end else begin
                    a = int'($urandom_range(0, 262143)) - 131072;
                    b = int'($urandom_range(0, 262143)) - 131072;
                end
                send(a, b, i == len - 1);
            end
        end
        rnd_ready = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        n = 0;
        while (expq.size() != 0 && n < 1000) begin
            step(took);
            n++;
        end
        check("drain_empty", expq.size(), 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
